// File: rtl/icache_dm_pkg.sv
// ============================================================================
// icache_dm_pkg : shared types and address-split helpers for icache_dm
// Rev 1.0
// ============================================================================
`default_nettype none

package icache_dm_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESP   = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

  // Tag keeps whatever address bits remain above index, offset and byte lane.
  function automatic int tag_width(input int lines, input int words);
    return ADDR_W - 2 - $clog2(lines) - $clog2(words);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_store.sv
// ============================================================================
// icache_store : flop-based valid/tag/data arrays with combinational read port
// Rev 1.0
// ============================================================================
`default_nettype none

module icache_store
  import icache_dm_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int TAG_W = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [$clog2(LINES)-1:0] rd_index,
  input  logic [$clog2(WORDS)-1:0] rd_offset,
  output logic                     rd_valid,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [DATA_W-1:0]        rd_word,
  input  logic                     wr_en,
  input  logic [$clog2(LINES)-1:0] wr_index,
  input  logic [$clog2(WORDS)-1:0] wr_offset,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     line_en,
  input  logic [$clog2(LINES)-1:0] line_index,
  input  logic [TAG_W-1:0]         line_tag,
  input  logic                     line_set_valid,
  input  logic                     flush
);

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag_arr  [LINES];
  logic [DATA_W-1:0] r_data_arr [LINES][WORDS];

  // A flush on the completing edge wins over setting the new line valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (line_en && line_set_valid) begin
      r_valid[line_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      r_data_arr[wr_index][wr_offset] <= wr_data;
    end
    if (line_en) begin
      r_tag_arr[line_index] <= line_tag;
    end
  end

  assign rd_valid = r_valid[rd_index];
  assign rd_tag   = r_tag_arr[rd_index];
  assign rd_word  = r_data_arr[rd_index][rd_offset];

endmodule

`default_nettype wire

// File: rtl/icache_dm.sv
// ============================================================================
// icache_dm : direct-mapped read-only instruction cache with line refill
// Rev 1.0
// ============================================================================
`default_nettype none

module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_req,
  output logic [DATA_W-1:0] icache_data,
  output logic              icache_rdy,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  localparam int C_OB = $clog2(WORDS);
  localparam int C_IB = $clog2(LINES);
  localparam int C_TB = tag_width(LINES, WORDS);
  localparam logic [C_OB-1:0] C_LAST = C_OB'(WORDS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [C_TB-1:0]   r_tag;
  logic [C_IB-1:0]   r_index;
  logic [C_OB-1:0]   r_offset;
  logic [C_OB-1:0]   r_cnt;
  logic [DATA_W-1:0] r_resp;
  logic              r_flush_pend;

  logic [C_TB-1:0]   w_req_tag;
  logic [C_IB-1:0]   w_req_index;
  logic [C_OB-1:0]   w_req_offset;
  logic              w_rd_valid;
  logic [C_TB-1:0]   w_rd_tag;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_hit;
  logic              w_word_done;
  logic              w_last_word;
  logic              w_unused;

  assign w_req_offset = icache_addr[C_OB+1:2];
  assign w_req_index  = icache_addr[C_IB+C_OB+1:C_OB+2];
  assign w_req_tag    = icache_addr[ADDR_W-1:C_IB+C_OB+2];
  assign w_unused     = ^icache_addr[1:0];

  assign w_hit       = w_rd_valid && (w_rd_tag == w_req_tag);
  assign w_word_done = (r_state == ST_REFILL) && mem_rdy;
  assign w_last_word = w_word_done && (r_cnt == C_LAST);

  icache_store #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (C_TB)
  ) u_store (
    .clock          (clock),
    .reset          (reset),
    .rd_index       (w_req_index),
    .rd_offset      (w_req_offset),
    .rd_valid       (w_rd_valid),
    .rd_tag         (w_rd_tag),
    .rd_word        (w_rd_word),
    .wr_en          (w_word_done),
    .wr_index       (r_index),
    .wr_offset      (r_cnt),
    .wr_data        (mem_rdata),
    .line_en        (w_last_word),
    .line_index     (r_index),
    .line_tag       (r_tag),
    .line_set_valid (!r_flush_pend),
    .flush          (flush)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    icache_rdy  = 1'b0;
    icache_data = r_resp;
    mem_req     = 1'b0;
    mem_addr    = '0;
    case (r_state)
      ST_IDLE: begin
        if (icache_req) begin
          w_next = w_hit ? ST_RESP : ST_REFILL;
        end
      end
      ST_RESP: begin
        icache_rdy = 1'b1;
        w_next     = ST_IDLE;
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_tag, r_index, r_cnt, 2'b00};
        if (w_last_word) begin
          w_next = ST_RESP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tag        <= '0;
      r_index      <= '0;
      r_offset     <= '0;
      r_cnt        <= '0;
      r_resp       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (icache_req && w_hit) begin
            r_resp <= w_rd_word;
          end else if (icache_req) begin
            r_tag    <= w_req_tag;
            r_index  <= w_req_index;
            r_offset <= w_req_offset;
            r_cnt    <= '0;
          end
        end
        ST_REFILL: begin
          if (mem_rdy) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == r_offset) begin
              r_resp <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
      // A flush mid-refill must keep the line it is filling from becoming valid.
      if (w_next == ST_IDLE) begin
        r_flush_pend <= 1'b0;
      end else if (flush && r_state == ST_REFILL) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
